game_vga_timing: RTL and testbench

Raster timing generator for the game video path: it produces the pixel coordinates, blanking flag and sync pulses that the sprite and background display blocks consume. It drives the pixel scan for every display block in the chain. The block is built from a system-clock pixel divider plus horizontal and vertical position counters. All outputs are registered, so downstream blocks see glitch-free coordinates and syncs aligned to one pixel-enable strobe.

---
 rtl/game_vga_pkg.sv | 28 ++
 rtl/game_vga_timing_if.sv | 24 ++
 rtl/game_vga_axis_counter.sv | 55 +++++
 rtl/game_vga_timing.sv | 92 +++++++++
 tb/tb_game_vga_timing.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/game_vga_pkg.sv
// Shared 640x480@60 raster constants so every display block derives its
// timing from one source.
package game_vga_pkg;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;

  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned X_BITS = 10;
  localparam int unsigned Y_BITS = 10;

  function automatic int unsigned axis_total(input int unsigned display,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return display + front + sync + back;
  endfunction

  localparam int unsigned H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

endpackage

// File: rtl/game_vga_timing_if.sv
// Raster bundle from the timing generator (master) to display blocks (slave).
interface game_vga_timing_if #(
   parameter int unsigned X_WIDTH = game_vga_pkg::X_BITS,
   parameter int unsigned Y_WIDTH = game_vga_pkg::Y_BITS
);
   logic               pixel_en;
   logic [X_WIDTH-1:0] pixel_x;
   logic [Y_WIDTH-1:0] pixel_y;
   logic               display_on;
   logic               hsync;
   logic               vsync;
   logic               line_start;
   logic               frame_start;

   modport master (
      output pixel_en, pixel_x, pixel_y, display_on,
             hsync, vsync, line_start, frame_start
   );

   modport slave (
      input  pixel_en, pixel_x, pixel_y, display_on,
             hsync, vsync, line_start, frame_start
   );
endinterface

// File: rtl/game_vga_axis_counter.sv
// One raster axis: position counter with registered active and sync flags.
// Used once for the horizontal and once for the vertical axis.
module game_vga_axis_counter
   import game_vga_pkg::*;
#(
   parameter int unsigned DISPLAY = H_DISPLAY,
   parameter int unsigned FRONT   = H_FRONT,
   parameter int unsigned SYNC    = H_SYNC,
   parameter int unsigned BACK    = H_BACK,
   parameter int unsigned WIDTH   = X_BITS
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             advance,
   output logic [WIDTH-1:0] pos,
   output logic             active,
   output logic             sync_n,
   output logic             wrap
);

   localparam int unsigned TOTAL   = axis_total(DISPLAY, FRONT, SYNC, BACK);
   localparam int unsigned SYNC_LO = DISPLAY + FRONT;
   localparam int unsigned SYNC_HI = SYNC_LO + SYNC;

   logic [WIDTH-1:0] pos_next;
   int unsigned      pos_next_u;

   // High on the last position, so the next advance returns to zero.
   assign wrap = (32'(pos) == TOTAL - 1);

   // NOTE: default first, so every path assigns pos_next and no latch is inferred.
   always_comb begin
      pos_next = pos;
      if (advance) begin
         pos_next = wrap ? '0 : pos + 1'b1;
      end
   end

   assign pos_next_u = 32'(pos_next);

   // Flags are decoded from the next position so they land with it.
   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos    <= WIDTH'(TOTAL - 1);
         active <= 1'b0;
         sync_n <= 1'b1;
      end else begin
         pos    <= pos_next;
         active <= (pos_next_u < DISPLAY);
         sync_n <= !((pos_next_u >= SYNC_LO) && (pos_next_u < SYNC_HI));
      end
   end

endmodule

// File: rtl/game_vga_timing.sv
// Raster timing generator: pixel-rate divider plus H/V axis counters, with
// coordinates, blanking, syncs and start pulses all updated on the same edge.
module game_vga_timing #(
   parameter int unsigned H_DISPLAY = game_vga_pkg::H_DISPLAY,
   parameter int unsigned H_FRONT   = game_vga_pkg::H_FRONT,
   parameter int unsigned H_SYNC    = game_vga_pkg::H_SYNC,
   parameter int unsigned H_BACK    = game_vga_pkg::H_BACK,
   parameter int unsigned V_DISPLAY = game_vga_pkg::V_DISPLAY,
   parameter int unsigned V_FRONT   = game_vga_pkg::V_FRONT,
   parameter int unsigned V_SYNC    = game_vga_pkg::V_SYNC,
   parameter int unsigned V_BACK    = game_vga_pkg::V_BACK,
   parameter int unsigned X_WIDTH   = game_vga_pkg::X_BITS,
   parameter int unsigned Y_WIDTH   = game_vga_pkg::Y_BITS,
   parameter int unsigned CLK_DIV   = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   game_vga_timing_if.master vga
);
   import game_vga_pkg::*;

   localparam int unsigned H_TOT = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
   localparam int unsigned V_TOT = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (64'(H_TOT) > (64'd1 << X_WIDTH)) begin : g_chk_h
      $error("game_vga_timing: H total does not fit in X_WIDTH");
   end
   if (64'(V_TOT) > (64'd1 << Y_WIDTH)) begin : g_chk_v
      $error("game_vga_timing: V total does not fit in Y_WIDTH");
   end
   if (CLK_DIV < 1) begin : g_chk_div
      $error("game_vga_timing: CLK_DIV must be at least 1");
   end

   logic [DIV_W-1:0]   div_cnt;
   logic               tick;
   logic [X_WIDTH-1:0] h_pos;
   logic [Y_WIDTH-1:0] v_pos;
   logic               h_active, v_active, h_sync_n, v_sync_n, h_wrap, v_wrap;
   logic               pixel_en_q, line_start_q, frame_start_q;

   // With CLK_DIV=1 the counter never leaves zero, so tick stays high.
   assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
   end

   game_vga_axis_counter #(
      .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
      .WIDTH(X_WIDTH)
   ) u_h (
      .clk(clk), .reset_n(reset_n), .advance(tick),
      .pos(h_pos), .active(h_active), .sync_n(h_sync_n), .wrap(h_wrap)
   );

   game_vga_axis_counter #(
      .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
      .WIDTH(Y_WIDTH)
   ) u_v (
      .clk(clk), .reset_n(reset_n), .advance(tick && h_wrap),
      .pos(v_pos), .active(v_active), .sync_n(v_sync_n), .wrap(v_wrap)
   );

   // Pulses are captured on the tick edge, alongside the counter update.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pixel_en_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         pixel_en_q    <= tick;
         line_start_q  <= tick && h_wrap;
         frame_start_q <= tick && h_wrap && v_wrap;
      end
   end

   assign vga.pixel_en    = pixel_en_q;
   assign vga.pixel_x     = h_pos;
   assign vga.pixel_y     = v_pos;
   assign vga.display_on  = h_active && v_active;
   assign vga.hsync       = h_sync_n;
   assign vga.vsync       = v_sync_n;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_game_vga_timing.sv
// Bench for game_vga_timing: a full-size and two tiny-timing instances, each
// with a cycle-count reference model feeding a scoreboard, plus raster statistics.
module tb_game_vga_timing;

   localparam int N_CFG = 3;
   localparam int unsigned CFG_HD [N_CFG] = '{640, 8, 8};
   localparam int unsigned CFG_HF [N_CFG] = '{16, 1, 1};
   localparam int unsigned CFG_HS [N_CFG] = '{96, 2, 2};
   localparam int unsigned CFG_HB [N_CFG] = '{48, 1, 1};
   localparam int unsigned CFG_VD [N_CFG] = '{480, 4, 4};
   localparam int unsigned CFG_VF [N_CFG] = '{10, 1, 1};
   localparam int unsigned CFG_VS [N_CFG] = '{2, 1, 1};
   localparam int unsigned CFG_VB [N_CFG] = '{33, 1, 1};
   localparam int unsigned CFG_CD [N_CFG] = '{2, 4, 1};

   logic clk = 1'b0;
   logic reset_n;
   int   n_compared = 0;
   int   n_mismatched = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   for (genvar gi = 0; gi < N_CFG; gi++) begin : g_cfg
      localparam int unsigned HD = CFG_HD[gi];
      localparam int unsigned HF = CFG_HF[gi];
      localparam int unsigned HS = CFG_HS[gi];
      localparam int unsigned HT = HD + HF + HS + CFG_HB[gi];
      localparam int unsigned VD = CFG_VD[gi];
      localparam int unsigned VF = CFG_VF[gi];
      localparam int unsigned VS = CFG_VS[gi];
      localparam int unsigned VT = VD + VF + VS + CFG_VB[gi];
      localparam int unsigned CD = CFG_CD[gi];
      localparam logic [25:0] RST_VEC = {1'b0, 10'(HT - 1), 10'(VT - 1), 5'b01100};

      game_vga_timing_if #(.X_WIDTH(10), .Y_WIDTH(10)) vif ();

      game_vga_timing #(
         .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(CFG_HB[gi]),
         .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(CFG_VB[gi]),
         .X_WIDTH(10), .Y_WIDTH(10), .CLK_DIV(CD)
      ) dut (
         .clk(clk), .reset_n(reset_n), .vga(vif)
      );

      logic [25:0] obs;
      assign obs = {vif.pixel_en, vif.pixel_x, vif.pixel_y, vif.display_on,
                    vif.hsync, vif.vsync, vif.line_start, vif.frame_start};

      // After n clk edges out of reset, n/CD ticks have happened.
      function automatic logic [25:0] expect_at(input int unsigned n);
         int unsigned k, p, x, y;
         logic pe;
         k = n / CD;
         if (k == 0) return RST_VEC;
         p  = k - 1;
         x  = p % HT;
         y  = (p / HT) % VT;
         pe = ((n % CD) == 0);
         return {pe, 10'(x), 10'(y), (x < HD) && (y < VD),
                 !((x >= HD + HF) && (x < HD + HF + HS)),
                 !((y >= VD + VF) && (y < VD + VF + VS)),
                 pe && (x == 0), pe && (x == 0) && (y == 0)};
      endfunction

      logic [25:0] sb_q[$];
      int unsigned n_clk = 0;

      // Reset events fall while clk is low; clk edges push one expectation each.
      always @(posedge clk or negedge reset_n) begin
         if (!reset_n) n_clk = 0;
         else if (clk) n_clk++;
         if (clk) sb_q.push_back(expect_at(n_clk));
      end

      always @(negedge reset_n) begin
         #1;
         check($sformatf("cfg%0d_async_reset", gi), 32'(obs), 32'(RST_VEC));
      end

      int unsigned line_cnt, hs_cnt, hs_first, hs_last;
      int unsigned frame_cnt, don_cnt, vs_cnt, max_y;
      bit line_seen = 0;
      bit frame_seen = 0;

      always @(negedge clk) begin
         if (sb_q.size() != 0) begin
            check($sformatf("cfg%0d_scoreboard", gi), 32'(obs), 32'(sb_q.pop_front()));
         end
         if (!reset_n) begin
            line_seen  = 0;
            frame_seen = 0;
         end else if (vif.pixel_en) begin
            if (vif.line_start) begin
               if (line_seen) begin
                  check($sformatf("cfg%0d_line_pixels", gi), line_cnt, HT);
                  check($sformatf("cfg%0d_hsync_pixels", gi), hs_cnt, HS);
                  check($sformatf("cfg%0d_hsync_first_x", gi), hs_first, HD + HF);
                  check($sformatf("cfg%0d_hsync_last_x", gi), hs_last, HD + HF + HS - 1);
               end
               line_seen = 1;
               line_cnt  = 0;
               hs_cnt    = 0;
            end
            if (vif.frame_start) begin
               if (frame_seen) begin
                  check($sformatf("cfg%0d_frame_pixels", gi), frame_cnt, HT * VT);
                  check($sformatf("cfg%0d_display_pixels", gi), don_cnt, HD * VD);
                  check($sformatf("cfg%0d_vsync_pixels", gi), vs_cnt, VS * HT);
                  check($sformatf("cfg%0d_max_y", gi), max_y, VT - 1);
               end
               frame_seen = 1;
               frame_cnt  = 0;
               don_cnt    = 0;
               vs_cnt     = 0;
               max_y      = 0;
            end
            line_cnt++;
            frame_cnt++;
            if (!vif.hsync) begin
               if (hs_cnt == 0) hs_first = 32'(vif.pixel_x);
               hs_last = 32'(vif.pixel_x);
               hs_cnt++;
            end
            if (vif.display_on) don_cnt++;
            if (!vif.vsync) vs_cnt++;
            if (32'(vif.pixel_y) > max_y) max_y = 32'(vif.pixel_y);
         end
      end
   end

   initial begin
      int unsigned cyc;
      bit found;

      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      cyc = 0;
      found = 0;
      while (!found && cyc < 16) begin
         @(negedge clk);
         cyc++;
         found = g_cfg[0].vif.pixel_en;
      end
      check("first_pixel_en_latency", cyc, 2);
      check("first_xy", {g_cfg[0].vif.pixel_x, g_cfg[0].vif.pixel_y}, 0);
      check("first_flags", {g_cfg[0].vif.frame_start, g_cfg[0].vif.line_start,
                            g_cfg[0].vif.display_on, g_cfg[0].vif.hsync,
                            g_cfg[0].vif.vsync}, 5'b11111);

      repeat (3500) @(negedge clk);

      cyc = 0;
      found = 0;
      while (!found && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         found = (g_cfg[1].vif.pixel_x == 10'd5) && (g_cfg[1].vif.pixel_y == 10'd3);
      end
      check("reach_mid_frame", found, 1);

      #1 reset_n = 1'b0;
      #2;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      cyc = 0;
      found = 0;
      while (!found && cyc < 32) begin
         @(negedge clk);
         cyc++;
         found = g_cfg[1].vif.frame_start;
      end
      check("restart_frame_start_latency", cyc, 4);
      check("restart_xy", {g_cfg[1].vif.pixel_x, g_cfg[1].vif.pixel_y}, 0);

      repeat (1500) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
